// File: rtl/spatz_pkg.sv
// Shared types, CSR addresses and helpers for the Spatz issue controller.
package spatz_pkg;

   localparam int VLEN    = 256;
   localparam int ELEN    = 32;
   localparam int NrVregs = 32;

   typedef logic [ELEN-1:0]              elen_t;
   typedef logic [$clog2(VLEN+1)-1:0]    vlen_t;
   typedef logic [4:0]                   vreg_t;
   typedef logic [NrVregs-1:0]           vreg_mask_t;

   // vsew: 0=8b, 1=16b, 2=32b; vlmul: 0..3 integer LMUL, 5..7 fractional, 4 reserved
   typedef struct packed {
      logic       vill;
      logic       vma;
      logic       vta;
      logic [2:0] vsew;
      logic [2:0] vlmul;
   } vtype_t;

   localparam vtype_t VTYPE_RESET = '{vill: 1'b1, vma: 1'b0, vta: 1'b0, vsew: 3'd0, vlmul: 3'd0};

   // Loads/stores form one contiguous range so routing is a simple range check
   typedef enum logic [4:0] {
      VCFG, VCSR,
      VADD, VSUB, VMUL, VAND, VOR, VXOR,
      VLE, VLSE, VLXE, VSE, VSSE, VSXE,
      VSLIDEUP, VSLIDEDOWN
   } op_e;

   typedef enum logic [1:0] {
      VFU   = 2'd0,
      VLSU  = 2'd1,
      VSLDU = 2'd2
   } unit_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } ctrl_state_e;

   localparam logic [11:0] CSR_VSTART = 12'h008;
   localparam logic [11:0] CSR_VL     = 12'hC20;
   localparam logic [11:0] CSR_VTYPE  = 12'hC21;
   localparam logic [11:0] CSR_VLENB  = 12'hC22;

   typedef struct packed {
      logic keep_vl;
   } op_cfg_t;

   typedef struct packed {
      logic [11:0] addr;
      logic        write_vstart;
      logic        set_vstart;
      logic        clear_vstart;
   } op_csr_t;

   typedef struct packed {
      op_e     op;
      vreg_t   vd;
      vreg_t   vs1;
      vreg_t   vs2;
      logic    use_vd;
      logic    use_vs1;
      logic    use_vs2;
      logic    use_rd;
      elen_t   rs1;
      elen_t   rs2;
      op_cfg_t op_cfg;
      op_csr_t op_csr;
      vtype_t  vtype;
      vlen_t   vl;
      elen_t   vstart;
   } spatz_req_t;

   typedef struct packed {
      logic       illegal;
      spatz_req_t instr;
   } decoder_rsp_t;

   // Execution unit that owns a given operation
   function automatic unit_e unit_of(input op_e op);
      if (op >= VLE && op <= VSXE)
         return VLSU;
      else if (op == VSLIDEUP || op == VSLIDEDOWN)
         return VSLDU;
      else
         return VFU;
   endfunction

   // Registers covered by a group starting at base; fractional LMUL still occupies one register
   function automatic vreg_mask_t group_mask(input vreg_t base, input logic [2:0] vlmul);
      logic [3:0] emul;
      vreg_t      idx;
      group_mask = '0;
      emul = vlmul[2] ? 4'd1 : (4'd1 << vlmul);
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < emul) begin
            idx = base + 5'(i);
            group_mask[idx] = 1'b1;
         end
      end
   endfunction

   // Architectural view of vtype as read through the CSR port
   function automatic elen_t vtype_to_elen(input vtype_t v);
      return {v.vill, 23'b0, v.vma, v.vta, v.vsew, v.vlmul};
   endfunction

endpackage

// File: rtl/spatz_vlmax_calc.sv
// Combinational vtype legality check and VLMAX computation.
module spatz_vlmax_calc
   import spatz_pkg::*;
(
   input  logic [2:0] vsew,
   input  logic [2:0] vlmul,
   output logic       vill,
   output vlen_t      vlmax
);

   logic [31:0] per_reg;
   logic [31:0] grouped;

   // SEW wider than ELEN or the reserved LMUL encoding makes vtype illegal
   always_comb begin
      vill    = (vsew >= 3'd3) || (vlmul == 3'd4);
      per_reg = 32'(VLEN) >> (32'd3 + 32'(vsew));
      if (!vlmul[2])
         grouped = per_reg << vlmul;
      else
         grouped = per_reg >> (4'd8 - {1'b0, vlmul});
      vlmax   = vill ? '0 : vlen_t'(grouped);
   end

endmodule

// File: rtl/spatz_controller.sv
// Spatz issue controller: CSR ownership, hazard scoreboard and unit dispatch.
module spatz_controller
   import spatz_pkg::*;
#(
   parameter int NrUnits = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               decoder_rsp_valid_i,
   output logic               decoder_rsp_ready_o,
   input  decoder_rsp_t       decoder_rsp_i,
   output spatz_req_t         spatz_req_o,
   output logic [NrUnits-1:0] spatz_req_valid_o,
   input  logic [NrUnits-1:0] spatz_req_ready_i,
   input  logic [NrUnits-1:0] unit_done_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output elen_t              rsp_data_o,
   output logic               rsp_illegal_o,
   output vtype_t             vtype_o,
   output vlen_t              vl_o
);

   ctrl_state_e        state_q, state_d;
   spatz_req_t         req_q;
   unit_e              unit_q;
   vtype_t             vtype_q;
   vlen_t              vl_q;
   elen_t              vstart_q;
   logic [NrUnits-1:0] busy_q;
   vreg_mask_t         mask_q [NrUnits];
   elen_t              rsp_data_q;
   logic               rsp_illegal_q;

   vreg_mask_t         sb;
   spatz_req_t         dec;
   spatz_req_t         stamped;
   unit_e              in_unit;
   logic               is_cfg, is_csr, in_dispatch;
   logic               hazard, accept, issue_fire;
   logic               cfg_vill;
   vlen_t              cfg_vlmax, cfg_vl;
   elen_t              csr_rd, vstart_new;
   logic               csr_illegal;

   spatz_vlmax_calc i_vlmax (
      .vsew  (decoder_rsp_i.instr.rs2[5:3]),
      .vlmul (decoder_rsp_i.instr.rs2[2:0]),
      .vill  (cfg_vill),
      .vlmax (cfg_vlmax)
   );

   // The scoreboard is the union of the register groups held by each busy unit
   always_comb begin
      sb = '0;
      for (int u = 0; u < NrUnits; u++) sb = sb | mask_q[u];
   end

   // Hazard check on the incoming instruction against the pre-update scoreboard
   always_comb begin
      dec         = decoder_rsp_i.instr;
      in_unit     = unit_of(dec.op);
      is_cfg      = (dec.op == VCFG);
      is_csr      = (dec.op == VCSR);
      in_dispatch = !decoder_rsp_i.illegal && !is_cfg && !is_csr;
      hazard      = 1'b0;
      if (dec.use_vs1 && |(group_mask(dec.vs1, vtype_q.vlmul) & sb)) hazard = 1'b1;
      if (dec.use_vs2 && |(group_mask(dec.vs2, vtype_q.vlmul) & sb)) hazard = 1'b1;
      if (dec.use_vd  && |(group_mask(dec.vd,  vtype_q.vlmul) & sb)) hazard = 1'b1;
      if (in_dispatch && busy_q[in_unit]) hazard = 1'b1;
      decoder_rsp_ready_o = (state_q == IDLE) && !hazard && !rst_i;
      accept      = decoder_rsp_valid_i && decoder_rsp_ready_o;
      issue_fire  = (state_q == ISSUE) && spatz_req_ready_i[unit_q];
      stamped        = dec;
      stamped.vtype  = vtype_q;
      stamped.vl     = vl_q;
      stamped.vstart = vstart_q;
   end

   // New vl for VCFG and read/modify values for VCSR
   always_comb begin
      if (cfg_vill)
         cfg_vl = '0;
      else if (dec.op_cfg.keep_vl)
         cfg_vl = (vl_q < cfg_vlmax) ? vl_q : cfg_vlmax;
      else
         cfg_vl = (dec.rs1 < elen_t'(cfg_vlmax)) ? vlen_t'(dec.rs1) : cfg_vlmax;

      csr_rd      = '0;
      csr_illegal = 1'b0;
      vstart_new  = vstart_q;
      unique case (dec.op_csr.addr)
         CSR_VSTART: begin
            csr_rd = vstart_q;
            if (dec.op_csr.write_vstart)      vstart_new = dec.rs1;
            else if (dec.op_csr.set_vstart)   vstart_new = vstart_q | dec.rs1;
            else if (dec.op_csr.clear_vstart) vstart_new = vstart_q & ~dec.rs1;
         end
         CSR_VL:    csr_rd = elen_t'(vl_q);
         CSR_VTYPE: csr_rd = vtype_to_elen(vtype_q);
         CSR_VLENB: csr_rd = elen_t'(VLEN / 8);
         default:   csr_illegal = 1'b1;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d           = state_q;
      spatz_req_valid_o = '0;
      rsp_valid_o       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = in_dispatch ? ISSUE : RESP;
         end
         ISSUE: begin
            spatz_req_valid_o[unit_q] = 1'b1;
            if (issue_fire) state_d = req_q.use_rd ? RESP : IDLE;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Architectural CSRs, latched request, unit occupancy and response data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q         <= '0;
         unit_q        <= VFU;
         vtype_q       <= VTYPE_RESET;
         vl_q          <= '0;
         vstart_q      <= '0;
         busy_q        <= '0;
         rsp_data_q    <= '0;
         rsp_illegal_q <= 1'b0;
         for (int u = 0; u < NrUnits; u++) mask_q[u] <= '0;
      end else begin
         if (accept) begin
            if (decoder_rsp_i.illegal) begin
               rsp_data_q    <= '0;
               rsp_illegal_q <= 1'b1;
            end else if (is_cfg) begin
               vtype_q       <= cfg_vill ? VTYPE_RESET
                                         : '{vill: 1'b0, vma: dec.rs2[7], vta: dec.rs2[6],
                                             vsew: dec.rs2[5:3], vlmul: dec.rs2[2:0]};
               vl_q          <= cfg_vl;
               vstart_q      <= '0;
               rsp_data_q    <= elen_t'(cfg_vl);
               rsp_illegal_q <= 1'b0;
            end else if (is_csr) begin
               rsp_data_q    <= csr_illegal ? '0 : csr_rd;
               rsp_illegal_q <= csr_illegal;
               if (!csr_illegal) vstart_q <= vstart_new;
            end else begin
               req_q         <= stamped;
               unit_q        <= in_unit;
               rsp_data_q    <= '0;
               rsp_illegal_q <= 1'b0;
            end
         end
         for (int u = 0; u < NrUnits; u++) begin
            if (unit_done_i[u]) begin
               busy_q[u] <= 1'b0;
               mask_q[u] <= '0;
            end
         end
         if (issue_fire) begin
            busy_q[unit_q] <= 1'b1;
            mask_q[unit_q] <= req_q.use_vd ? group_mask(req_q.vd, req_q.vtype.vlmul) : '0;
            vstart_q       <= '0;
         end
      end
   end

   assign spatz_req_o   = req_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_illegal_o = rsp_illegal_q;
   assign vtype_o       = vtype_q;
   assign vl_o          = vl_q;

endmodule

// File: doc/spatz_controller.md
Name: spatz_controller

Overview:
Central issue controller of the Spatz vector unit.
- Accepts decoded requests (decoder_rsp_t) from the decoder over a valid/ready handshake.
- Owns the vl/vtype/vstart architectural state and executes VCFG and VCSR itself.
- Stamps every other op with the current vtype/vl/vstart and dispatches it to one of three units: VFU (arith), VLSU (load/store) or VSLDU (slide).
- Enforces register hazards with a 32-entry vector-register scoreboard and returns scalar results and illegal flags to the core.

Parameters:
NrUnits, 3, number of execution units (0=VFU, 1=VLSU, 2=VSLDU).
VLEN, spatz_pkg::VLEN (256 in bench), bits per vector register.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
decoder_rsp_valid_i  in  1  decoded instruction valid
decoder_rsp_ready_o  out  1  controller accepts instruction
decoder_rsp_i  in  decoder_rsp_t  illegal flag plus spatz_req_t
spatz_req_o  out  spatz_req_t  request to units, vtype/vl/vstart filled in
spatz_req_valid_o  out  NrUnits  one-hot request valid per unit
spatz_req_ready_i  in  NrUnits  unit accepts request
unit_done_i  in  NrUnits  single-cycle pulse, unit finished its op
rsp_valid_o  out  1  scalar response valid
rsp_ready_i  in  1  core accepts response
rsp_data_o  out  elen_t  rd value (new vl or CSR value)
rsp_illegal_o  out  1  instruction was illegal
vtype_o  out  vtype_t  current vtype
vl_o  out  vlen_t  current vl

Behaviour:
- Reset (any cycle, asynchronous):
  - State goes to IDLE.
  - vtype = {vill=1, others 0}; vl = 0; vstart = 0.
  - Scoreboard all clear; unit_busy all 0.
  - decoder_rsp_ready_o=0, spatz_req_valid_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_illegal_o=0.
  - An in-flight request is dropped; no done pulse is expected after reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - decoder_rsp_ready_o = 1 unless the hazard check fails. The check is purely combinational on decoder_rsp_i.
  - Hazard check fails when any used vs1/vs2/vd register group overlaps a scoreboard-busy bit, or the target unit has unit_busy set.
  - On accept, the next state depends on the instruction:
    - illegal → RESP with illegal flag.
    - VCFG → update CSRs, → RESP.
    - VCSR → read CSR, → RESP.
    - otherwise latch request → ISSUE.
- ISSUE:
  - spatz_req_valid_o[unit] held with spatz_req_o stable until spatz_req_ready_i[unit] is seen.
  - On handshake:
    - set scoreboard bits of the vd group (if use_vd);
    - set unit_busy[unit] and store vd/group size per unit;
    - vstart := 0;
    - if use_rd → RESP, else → IDLE.
- RESP:
  - rsp_valid_o held until rsp_ready_i; then → IDLE.
  - rsp_data_o/rsp_illegal_o are stable while valid.
- Routing: VLE..VSXE → unit 1; VSLIDEUP/VSLIDEDOWN → unit 2; all other ops → unit 0.
- Register group size: emul = 1 << vlmul for vlmul 0..3; emul = 1 for fractional vlmul. A group is vd..vd+emul-1, wrapping mod 32.
- unit_done_i[u]: clears the stored vd group bits and unit_busy[u] in the same cycle.
  - If it coincides with an IDLE hazard check on those registers, the check sees the pre-clear state and stalls one cycle.
  - If it coincides with a new issue to another unit, set and clear of different bits both apply.
- VCFG (rs1 = AVL, rs2 = raw vtype):
  - vill is set, vl := 0 and rd := 0 when either:
    - vsew ≥ 3 (SEW > ELEN), or
    - vlmul == 4 (reserved).
  - Otherwise VLMAX = (VLEN >> (3+vsew)) << vlmul for vlmul ≤ 3, or >> (8-vlmul) when fractional.
  - keep_vl=1: vl unchanged, clamped to the new VLMAX.
  - Otherwise vl := min(AVL, VLMAX).
  - rd = new vl. vstart := 0.
- VCSR by op_csr.addr:
  - 0x008 vstart: write_vstart → :=rs1; set_vstart → |=rs1; clear_vstart → &=~rs1. rd = old value.
  - 0xC20 vl, 0xC21 vtype, 0xC22 vlenb (=VLEN/8): read only.
  - Any other address → illegal response.

Decomposition:
- Add to spatz_pkg:
  - unit_e enum (VFU, VLSU, VSLDU);
  - CSR address localparams;
  - ctrl_state_e.
- Sub-module spatz_vlmax_calc: combinational vtype → {vill, vlmax}; reused by the decoder checks.

Test Plan:
- VLEN=256, VCFG rs1=100, vsew=2, vlmul=0 → rsp_data_o=8, vl_o=8. Then rs1=5 → rsp_data_o=5.
- VCFG vsew=3 → vtype_o.vill=1, rsp_data_o=0. A subsequent VCSR read 0xC22 → rsp_data_o=32.
- RAW hazard, LMUL=2:
  - VADD vd=4 issued to VFU; next VADD vs1=5 → decoder_rsp_ready_o=0.
  - unit_done_i[0] pulse → accepted one cycle later, spatz_req_valid_o=3'b001.
- Unit backpressure:
  - VLE vd=8 with spatz_req_ready_i[1]=0 for 5 cycles → valid held, spatz_req_o constant.
  - Ready → scoreboard bit 8 set, FSM back to IDLE.
- Parallel units: VLE to VLSU outstanding, VSLIDEUP vd=12 → issues to VSLDU without stall. A second VLE stalls until unit_done_i[1].
- Illegal instruction → rsp_illegal_o=1, no spatz_req_valid_o. Assert rst_i during ISSUE → all outputs 0 immediately and vtype_o.vill=1.
